// File: rtl/rgb_to_yuv_encoder_if.sv
// -----------------------------------------------------------------------------
// rgb_to_yuv_encoder_if
//   Groups the frame-encoder handshake (start/done) with the shared 16-bit
//   SRAM port.
//
//   Signals
//     start            one-cycle pulse that launches a frame
//     done             one-cycle pulse at frame end
//     SRAM_read_data   16-bit read bus returned by the SRAM
//     SRAM_address     18-bit word address
//     SRAM_write_data  16-bit write data
//     SRAM_we_n        active-low write enable
//
//   Modports
//     master  the encoder (drives address / write data / we_n / done)
//     slave   the SRAM plus top-level controller side
// -----------------------------------------------------------------------------
interface rgb_to_yuv_encoder_if;
  logic        start;
  logic        done;
  logic [15:0] SRAM_read_data;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;

  modport master (
    input  start,
    input  SRAM_read_data,
    output done,
    output SRAM_address,
    output SRAM_write_data,
    output SRAM_we_n
  );

  modport slave (
    output start,
    output SRAM_read_data,
    input  done,
    input  SRAM_address,
    input  SRAM_write_data,
    input  SRAM_we_n
  );
endinterface

// File: rtl/rgb_to_yuv_encoder.sv
// -----------------------------------------------------------------------------
// rgb_to_yuv_encoder
//   Reads an interleaved 8-bit RGB frame from SRAM, converts each pixel to
//   YUV with fixed-point arithmetic and writes packed Y, U and V planes back
//   in the layout the decoder consumes. U/V are kept for even columns only.
//
//   Work unit is a group of 4 pixels, 20 cycles per group:
//     RD0..RD5   issue 6 RGB word reads
//     CAP0..CAP1 drain the 2-cycle SRAM read pipeline
//     MAC0..MAC7 one sample per cycle: Y0 Y1 Y2 Y3 U0 U2 V0 V2
//     WR0..WR3   write {Y1,Y0}, {Y3,Y2}, {U2,U0}, {V2,V0}
//
//   Ports
//     Clock   system clock
//     resetn  asynchronous active-low reset
//     bus     handshake + SRAM port (master side)
// -----------------------------------------------------------------------------
module rgb_to_yuv_encoder #(
  parameter int          IMG_WIDTH  = 320,
  parameter int          IMG_HEIGHT = 240,
  parameter logic [17:0] Y_BASE     = 18'd0,
  parameter logic [17:0] U_BASE     = 18'd38400,
  parameter logic [17:0] V_BASE     = 18'd57600,
  parameter logic [17:0] RGB_BASE   = 18'd146944
) (
  input logic                  Clock,
  input logic                  resetn,
  rgb_to_yuv_encoder_if.master bus
);

  localparam int NUM_GROUPS = IMG_WIDTH * IMG_HEIGHT / 4;
  localparam int GW         = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam logic [GW-1:0] LAST_GROUP = GW'(NUM_GROUPS - 1);

  typedef enum logic [4:0] {
    IDLE,
    RD0, RD1, RD2, RD3, RD4, RD5,
    CAP0, CAP1,
    MAC0, MAC1, MAC2, MAC3, MAC4, MAC5, MAC6, MAC7,
    WR0, WR1, WR2, WR3,
    DONE
  } state_t;

  state_t       state_reg;
  logic [GW-1:0] group_reg;
  logic [17:0]  rgb_ptr_reg;     // next RGB word address to read
  logic [17:0]  addr_reg;
  logic [15:0]  wdata_reg;
  logic         we_n_reg;
  logic         done_reg;
  logic [15:0]  words_reg   [6]; // raw RGB words of the current group
  logic [7:0]   samples_reg [8]; // Y0 Y1 Y2 Y3 U0 U2 V0 V2

  logic [17:0]  group_ext;
  assign group_ext = 18'(group_reg);

  // ---------------------------------------------------------------------------
  // Unpack the 6 captured words into per-pixel R/G/B. Each pixel pair occupies
  // three words: {G0,R0}, {R1,B0}, {B1,G1}.
  // ---------------------------------------------------------------------------
  logic [7:0] pix_r [4];
  logic [7:0] pix_g [4];
  logic [7:0] pix_b [4];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_pair
      assign pix_r[2*gi]   = words_reg[3*gi][7:0];
      assign pix_g[2*gi]   = words_reg[3*gi][15:8];
      assign pix_b[2*gi]   = words_reg[3*gi+1][7:0];
      assign pix_r[2*gi+1] = words_reg[3*gi+1][15:8];
      assign pix_g[2*gi+1] = words_reg[3*gi+2][7:0];
      assign pix_b[2*gi+1] = words_reg[3*gi+2][15:8];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State decode for the datapath side effects.
  // ---------------------------------------------------------------------------
  logic       capture_en;
  logic       mac_en;
  logic [2:0] mac_step;

  always_comb begin
    capture_en = 1'b0;
    mac_en     = 1'b0;
    mac_step   = 3'd0;
    case (state_reg)
      RD2, RD3, RD4, RD5, CAP0, CAP1: capture_en = 1'b1;
      MAC0: begin mac_en = 1'b1; mac_step = 3'd0; end
      MAC1: begin mac_en = 1'b1; mac_step = 3'd1; end
      MAC2: begin mac_en = 1'b1; mac_step = 3'd2; end
      MAC3: begin mac_en = 1'b1; mac_step = 3'd3; end
      MAC4: begin mac_en = 1'b1; mac_step = 3'd4; end
      MAC5: begin mac_en = 1'b1; mac_step = 3'd5; end
      MAC6: begin mac_en = 1'b1; mac_step = 3'd6; end
      MAC7: begin mac_en = 1'b1; mac_step = 3'd7; end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shared three-multiplier MAC. Steps 0..3 are Y of pixels 0..3; steps 4..7
  // alternate pixel 0 / pixel 2 for U then V (odd pixels simply dropped).
  // ---------------------------------------------------------------------------
  logic [1:0]         mac_pix;
  logic signed [31:0] coef_r, coef_g, coef_b, offset;
  logic signed [31:0] r_s, g_s, b_s, acc, acc_sh;
  logic [7:0]         sample_next;

  always_comb begin
    mac_pix = mac_step[2] ? {mac_step[0], 1'b0} : mac_step[1:0];
    r_s     = {24'd0, pix_r[mac_pix]};
    g_s     = {24'd0, pix_g[mac_pix]};
    b_s     = {24'd0, pix_b[mac_pix]};
    case (mac_step[2:1])
      2'b10: begin
        coef_r = -32'sd9699;  coef_g = -32'sd19071; coef_b = 32'sd28770;
        offset = 32'sd8421376;
      end
      2'b11: begin
        coef_r = 32'sd28770;  coef_g = -32'sd24117; coef_b = -32'sd4653;
        offset = 32'sd8421376;
      end
      default: begin
        coef_r = 32'sd16843;  coef_g = 32'sd33030;  coef_b = 32'sd6423;
        offset = 32'sd1081344;
      end
    endcase
    acc    = coef_r * r_s + coef_g * g_s + coef_b * b_s + offset;
    acc_sh = acc >>> 16;
    if (acc_sh < 32'sd0)
      sample_next = 8'd0;
    else if (acc_sh > 32'sd255)
      sample_next = 8'd255;
    else
      sample_next = acc_sh[7:0];
  end

  // ---------------------------------------------------------------------------
  // FSM with registered SRAM outputs. Address and write data are loaded on the
  // edge that enters the state in which they must be visible.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= IDLE;
      group_reg   <= '0;
      rgb_ptr_reg <= '0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      we_n_reg    <= 1'b1;
      done_reg    <= 1'b0;
      for (int i = 0; i < 6; i++) words_reg[i] <= '0;
      for (int i = 0; i < 8; i++) samples_reg[i] <= '0;
    end else begin
      done_reg <= 1'b0;
      we_n_reg <= 1'b1;

      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            state_reg   <= RD0;
            group_reg   <= '0;
            addr_reg    <= RGB_BASE;
            rgb_ptr_reg <= RGB_BASE + 18'd1;
          end
        end
        RD0, RD1, RD2, RD3, RD4: begin
          case (state_reg)
            RD0:     state_reg <= RD1;
            RD1:     state_reg <= RD2;
            RD2:     state_reg <= RD3;
            RD3:     state_reg <= RD4;
            default: state_reg <= RD5;
          endcase
          addr_reg    <= rgb_ptr_reg;
          rgb_ptr_reg <= rgb_ptr_reg + 18'd1;
        end
        RD5:  state_reg <= CAP0;
        CAP0: state_reg <= CAP1;
        CAP1: state_reg <= MAC0;
        MAC0: state_reg <= MAC1;
        MAC1: state_reg <= MAC2;
        MAC2: state_reg <= MAC3;
        MAC3: state_reg <= MAC4;
        MAC4: state_reg <= MAC5;
        MAC5: state_reg <= MAC6;
        MAC6: state_reg <= MAC7;
        MAC7: begin
          state_reg <= WR0;
          addr_reg  <= Y_BASE + (group_ext << 1);
          wdata_reg <= {samples_reg[1], samples_reg[0]};
          we_n_reg  <= 1'b0;
        end
        WR0: begin
          state_reg <= WR1;
          addr_reg  <= Y_BASE + (group_ext << 1) + 18'd1;
          wdata_reg <= {samples_reg[3], samples_reg[2]};
          we_n_reg  <= 1'b0;
        end
        WR1: begin
          state_reg <= WR2;
          addr_reg  <= U_BASE + group_ext;
          wdata_reg <= {samples_reg[5], samples_reg[4]};
          we_n_reg  <= 1'b0;
        end
        WR2: begin
          state_reg <= WR3;
          addr_reg  <= V_BASE + group_ext;
          wdata_reg <= {samples_reg[7], samples_reg[6]};
          we_n_reg  <= 1'b0;
        end
        WR3: begin
          if (group_reg == LAST_GROUP) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end else begin
            // rgb_ptr_reg already points at the next group's first word.
            state_reg   <= RD0;
            group_reg   <= group_reg + 1'b1;
            addr_reg    <= rgb_ptr_reg;
            rgb_ptr_reg <= rgb_ptr_reg + 18'd1;
          end
        end
        DONE:    state_reg <= IDLE;  // start is not looked at here
        default: state_reg <= IDLE;
      endcase

      // Read data arrives two cycles after its address; shifting keeps the
      // first captured word in slot 0.
      if (capture_en) begin
        for (int i = 0; i < 5; i++) words_reg[i] <= words_reg[i+1];
        words_reg[5] <= bus.SRAM_read_data;
      end

      if (mac_en) samples_reg[mac_step] <= sample_next;
    end
  end

  assign bus.SRAM_address    = addr_reg;
  assign bus.SRAM_write_data = wdata_reg;
  assign bus.SRAM_we_n       = we_n_reg;
  assign bus.done            = done_reg;

endmodule
